// File: rtl/bitreverse_feeder_pkg.sv
// Shared sizing, beat type and drain FSM encoding for the bitReverse input feeder.
package bitreverse_feeder_pkg;

  localparam int DATA_SIZE_ARB = 32;
  localparam int PE_NUMBER     = 32;
  localparam int BEATS         = 16;
  localparam int BEAT_W        = 4;
  localparam int WPF           = PE_NUMBER * BEATS;
  localparam int LANE_W        = $clog2(PE_NUMBER);
  localparam int BEAT_DW       = DATA_SIZE_ARB * PE_NUMBER;

  // Lane k occupies bits [k*DATA_SIZE_ARB +: DATA_SIZE_ARB]
  typedef logic [PE_NUMBER-1:0][DATA_SIZE_ARB-1:0] beat_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/bitreverse_feeder_if.sv
// Word-stream input and packed-beat output bundle of the feeder.
interface bitreverse_feeder_if;
  import bitreverse_feeder_pkg::*;

  logic [DATA_SIZE_ARB-1:0] in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  beat_t                    br_data;
  logic [BEAT_W-1:0]        br_cycle;
  logic                     br_valid;
  logic                     br_first;
  logic                     frame_err;

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, br_data, br_cycle, br_valid, br_first, frame_err
  );

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, br_data, br_cycle, br_valid, br_first, frame_err
  );

endinterface

// File: rtl/bitreverse_feeder_ram.sv
// Ping-pong frame store: one write port, one registered read port, address {bank, beat}.
module feeder_frame_ram #(
  parameter int W     = 1024,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/bitreverse_feeder.sv
// Packs 32-bit coefficients into PE_NUMBER-wide beats, buffers whole frames in two
// banks and replays each completed frame to bitReverse as BEATS back-to-back beats.
module bitreverse_feeder
  import bitreverse_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  bitreverse_feeder_if.slave bus
);

  logic [PE_NUMBER-2:0][DATA_SIZE_ARB-1:0] r_lane;
  logic [LANE_W-1:0] r_word;
  logic [BEAT_W-1:0] r_wbeat;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full;
  logic [BEAT_W-1:0] r_rd_beat;
  logic [BEAT_W-1:0] r_rd_idx;
  logic [1:0]        r_vld_pipe;
  logic [BEAT_W-1:0] r_br_cycle;
  logic              r_br_first;
  logic              r_frame_err;
  beat_t             r_br_data;
  drain_state_e      r_state;

  drain_state_e      w_state_nxt;
  logic              w_acc;
  logic              w_beat_done;
  logic              w_frame_done;
  logic              w_issue;
  logic              w_rd_done;
  logic [BEAT_W-1:0] w_issue_beat;
  beat_t             w_wbeat;
  beat_t             w_rdata;

  assign bus.in_ready  = !r_full[r_wr_bank];
  assign w_acc         = bus.in_valid & bus.in_ready;
  assign w_beat_done   = w_acc && (r_word == LANE_W'(PE_NUMBER - 1));
  assign w_frame_done  = w_beat_done && (r_wbeat == BEAT_W'(BEATS - 1));
  // Last lane bypasses the packing register so the beat is written the cycle it completes
  assign w_wbeat       = {bus.in_data, r_lane};

  assign bus.br_data   = r_br_data;
  assign bus.br_cycle  = r_br_cycle;
  assign bus.br_valid  = r_vld_pipe[1];
  assign bus.br_first  = r_br_first;
  assign bus.frame_err = r_frame_err;

  always_ff @(posedge clk) begin
    for (int k = 0; k < PE_NUMBER - 1; k++)
      if (w_acc && r_word == LANE_W'(k)) r_lane[k] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word      <= '0;
      r_wbeat     <= '0;
      r_wr_bank   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_acc) begin
      r_word <= r_word + LANE_W'(1);
      if (w_beat_done) r_wbeat <= r_wbeat + BEAT_W'(1);
      if (w_frame_done) r_wr_bank <= ~r_wr_bank;
      // Frame length is fixed; in_last is only cross-checked against the word count
      if (bus.in_last != w_frame_done) r_frame_err <= 1'b1;
    end
  end

  // Set and clear always target different banks, so both may land on one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_frame_done && r_wr_bank == 1'(b))   r_full[b] <= 1'b1;
        else if (w_rd_done && r_rd_bank == 1'(b)) r_full[b] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_beat = r_rd_beat;
    w_rd_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt  = ST_DRAIN;
          w_issue      = 1'b1;
          w_issue_beat = '0;
        end
      end
      ST_DRAIN: begin
        w_issue = 1'b1;
        if (r_rd_beat == BEAT_W'(BEATS - 1)) begin
          w_rd_done = 1'b1;
          if (!r_full[~r_rd_bank]) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_beat <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_rd_beat <= w_issue_beat + BEAT_W'(1);
      if (w_rd_done) r_rd_bank <= ~r_rd_bank;
    end
  end

  feeder_frame_ram #(
    .W     (BEAT_DW),
    .DEPTH (2 * BEATS),
    .AW    (BEAT_W + 1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_beat_done),
    .i_waddr ({r_wr_bank, r_wbeat}),
    .i_wdata (w_wbeat),
    .i_re    (w_issue),
    .i_raddr ({r_rd_bank, w_issue_beat}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_rd_idx   <= '0;
      r_br_cycle <= '0;
      r_br_first <= 1'b0;
      r_br_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_issue};
      if (w_issue) r_rd_idx <= w_issue_beat;
      r_br_first <= r_vld_pipe[0] && (r_rd_idx == '0);
      if (r_vld_pipe[0]) begin
        r_br_cycle <= r_rd_idx;
        r_br_data  <= w_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bitreverse_feeder.sv
// Directed frame vectors plus hand-written latency, backpressure and reset sequences.
module tb_bitreverse_feeder;
  import bitreverse_feeder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitreverse_feeder_if bus();
  bitreverse_feeder dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] base;
    int          last_pos;
    int          duty;
    bit          exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          mon_beat = 0;
  bit          mon_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: beat b, lane k of a frame whose first word is 'base' carries base + PE_NUMBER*b + k
  always @(negedge clk) begin
    logic [31:0] eb;
    logic [31:0] ew;
    int          bad;
    if (reset) begin
      mon_beat = 0;
      exp_q.delete();
    end else if (mon_en) begin
      if (bus.br_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(bus.br_cycle), 64'hFFFF);
        end else begin
          eb = exp_q[0];
          chk("br_cycle", 64'(bus.br_cycle), 64'(mon_beat));
          chk("br_first", 64'(bus.br_first), 64'(mon_beat == 0));
          bad = 0;
          for (int k = 0; k < PE_NUMBER; k++) begin
            ew = eb + 32'(PE_NUMBER * mon_beat + k);
            if (bus.br_data[k] !== ew) begin
              bad = k;
              break;
            end
          end
          chk("br_data_lane", 64'(bus.br_data[bad]), 64'(eb + 32'(PE_NUMBER * mon_beat + bad)));
          if (mon_beat == BEATS - 1) begin
            void'(exp_q.pop_front());
            mon_beat = 0;
          end else begin
            mon_beat++;
          end
        end
      end else if (mon_beat != 0) begin
        chk("br_valid_gap", 64'(bus.br_valid), 64'd1);
        void'(exp_q.pop_front());
        mon_beat = 0;
      end
    end
  end

  task automatic send_words(input logic [31:0] base, input int n, input int last_pos,
                            input int duty, output int stalls);
    int i = 0;
    int budget = 0;
    bit acc;
    stalls = 0;
    while (i < n) begin
      if (budget > n * 20 + 2000) begin
        chk("send_timeout", 64'(i), 64'(n));
        break;
      end
      budget++;
      bus.in_valid = ($urandom_range(0, 99) < duty);
      bus.in_data  = base + 32'(i);
      bus.in_last  = (i == last_pos);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.in_valid && !bus.in_ready) stalls++;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        if (i % WPF == 0) exp_q.push_back(base + 32'(i - WPF));
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.br_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_br_valid"}, 64'(bus.br_valid), 64'd0);
    chk({tag, "_br_first"}, 64'(bus.br_first), 64'd0);
    chk({tag, "_br_cycle"}, 64'(bus.br_cycle), 64'd0);
    chk({tag, "_br_data_nz"}, 64'(bus.br_data != '0), 64'd0);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_frame_err"}, 64'(bus.frame_err), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   stalls;
    int   n;
    bit   acc;

    // back-to-back full-rate frames, 30% duty frames, then framing errors (sticky)
    vecs[0] = '{32'h0001_0000, 511, 100, 1'b0};
    vecs[1] = '{32'h0002_0000, 511, 100, 1'b0};
    vecs[2] = '{32'h0003_0000, 511, 100, 1'b0};
    vecs[3] = '{32'h0004_0000, 511,  30, 1'b0};
    vecs[4] = '{32'h0005_0000, 511,  30, 1'b0};
    vecs[5] = '{32'h0006_0000, 100, 100, 1'b1};
    vecs[6] = '{32'h0007_0000, 511,  30, 1'b1};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Single frame and first-beat latency
    @(posedge clk);
    #1;
    send_words(32'h0, WPF, WPF - 1, 100, stalls);
    chk("single_stalls", 64'(stalls), 64'd0);
    @(negedge clk);
    chk("lat_after_e0", 64'(bus.br_valid), 64'd0);
    @(negedge clk);
    chk("lat_after_e1", 64'(bus.br_valid), 64'd0);
    @(negedge clk);
    chk("lat_after_e2_valid", 64'(bus.br_valid), 64'd1);
    chk("lat_after_e2_cycle", 64'(bus.br_cycle), 64'd0);
    chk("lat_after_e2_first", 64'(bus.br_first), 64'd1);
    wait_drain("single_drain");
    chk("single_frame_err", 64'(bus.frame_err), 64'd0);

    @(posedge clk);
    #1;
    for (int v = 0; v < 7; v++) begin
      send_words(vecs[v].base, WPF, vecs[v].last_pos, vecs[v].duty, stalls);
      chk($sformatf("vec%0d_stalls", v), 64'(stalls), 64'd0);
      chk($sformatf("vec%0d_frame_err", v), 64'(bus.frame_err), 64'(vecs[v].exp_err));
    end
    wait_drain("table_drain");

    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'(bus.frame_err), 64'd0);

    // Backpressure: hold the drain FSM idle so both banks fill
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    force dut.r_state = ST_IDLE;
    send_words(32'h0008_0000, 2 * WPF, -1, 100, stalls);
    chk("bp_fill_stalls", 64'(stalls), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0009_0000;
    bus.in_last  = 1'b0;
    @(negedge clk);
    chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
    release dut.r_state;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      @(negedge clk);
      acc = bus.in_ready;
    end
    chk("bp_ready_rise", 64'(acc), 64'd1);
    // Bank 0 drains 16 beats after release; word 1024 goes in on the following edge
    chk("bp_accept_edge", 64'((n + 1 >= 16) && (n + 1 <= 17)), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    do_reset();
    @(negedge clk);
    chk_reset_vals("bp_rst");
    mon_en = 1'b1;

    // Reset mid-frame discards the partial frame
    @(posedge clk);
    #1;
    send_words(32'h000A_0000, 300, -1, 100, stalls);
    do_reset();
    @(negedge clk);
    chk_reset_vals("mid_rst");
    @(posedge clk);
    #1;
    send_words(32'h000B_0000, WPF, WPF - 1, 100, stalls);
    chk("mid_stalls", 64'(stalls), 64'd0);
    wait_drain("mid_drain");
    chk("mid_frame_err", 64'(bus.frame_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitreverse_feeder.md
# bitreverse_feeder

Upstream stage for the `bitReverse` permutation block. Accepts polynomial coefficients as a 32-bit word stream with valid/ready handshake and packs `PE_NUMBER` words into one wide beat. Buffers each whole frame in a ping-pong pair of banks. Replays a completed frame to `bitReverse` as `BEATS` beats on consecutive cycles, with the 4-bit beat index `bitReverse` expects. Filling one bank overlaps draining the other.

## Interface
- `DATA_SIZE_ARB`, 32: coefficient width in bits, shared define.
- `PE_NUMBER`, 32: coefficients per beat, shared define.
- `BEATS`, 16: beats per frame; must equal 2^width of `br_cycle`.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  `DATA_SIZE_ARB`  one coefficient.
- `in_valid`  in  1  `in_data` and `in_last` valid.
- `in_last`  in  1  marks the final word of a frame.
- `in_ready`  out  1  feeder can accept a word this cycle.
- `br_data`  out  `DATA_SIZE_ARB*PE_NUMBER`  packed beat; word k sits at bits [k*DATA_SIZE_ARB +: DATA_SIZE_ARB].
- `br_cycle`  out  4  beat index 0..BEATS-1, drives `bitReverse` cycle input.
- `br_valid`  out  1  `br_data`/`br_cycle` valid.
- `br_first`  out  1  high with beat 0 of each frame.
- `frame_err`  out  1  sticky `in_last` framing error.

## Operation
- Frame size: WPF = PE_NUMBER*BEATS words (512 by default).
- Fill side:
  - Word counter counts 0..PE_NUMBER-1 and beat counter counts 0..BEATS-1, both into bank `wr_bank`.
  - Word k of a beat lands in lane k; the beat is written to RAM when lane PE_NUMBER-1 is accepted.
  - A word is accepted when `in_valid & in_ready`.
  - `in_ready = !full[wr_bank]`.
- Frame close:
  - Accepting word WPF-1 sets `full[wr_bank]`, toggles `wr_bank` and clears both counters.
  - The frame closes on the word count only; `in_last` never closes it early.
- `frame_err` is set on `in_last=1` for word ≠ WPF-1, or `in_last=0` for word WPF-1. It clears only on reset.
- Drain FSM, states IDLE and DRAIN:
  - IDLE→DRAIN when `full[rd_bank]`. Beat 0 read issues on the transition edge.
  - In DRAIN, one beat read is issued per cycle. On issuing beat BEATS-1:
    - clear `full[rd_bank]` and toggle `rd_bank`;
    - if the new `rd_bank` is full, stay in DRAIN and issue its beat 0 next cycle (zero-gap back-to-back frames);
    - otherwise go to IDLE.
- Outputs are registered behind the 1-cycle RAM read:
  - `br_valid`/`br_cycle`/`br_first` follow the issued read index by exactly one cycle;
  - `br_cycle` increments by 1 per valid beat and wraps BEATS-1→0 only at a frame boundary.
- Simultaneous set and clear of `full` on different banks in one cycle: both take effect. They can never target the same bank.
- Reset:
  - clears `full[1:0]`, both bank pointers and counters, and `frame_err`;
  - puts the FSM in IDLE and drives `br_valid`/`br_first` to 0, `br_cycle` to 0, `br_data` to 0;
  - `in_ready` is 1 from the first cycle after reset.
  - Reset mid-frame discards partial and buffered frames; RAM contents are not cleared.

## Timing
- Last word of a frame accepted at edge E0 → `full` set at E0, FSM enters DRAIN at E1, first beat (`br_valid=1`, `br_cycle=0`, `br_first=1`) is visible after E2.
- Frame drains in exactly BEATS consecutive cycles; `br_valid` never drops inside a frame.
- Bank being drained is freed at the edge issuing its last read. `in_ready` can rise for that bank the following cycle.
- Sustained input at 1 word/cycle never stalls: filling a frame takes WPF cycles, draining takes BEATS.

## Structure
- Shared package/header holds:
  - `DATA_SIZE_ARB`, `PE_NUMBER`, BEATS and WPF;
  - beat-index width (4);
  - the FSM state encoding.
- Sub-module `feeder_frame_ram`: simple dual-port RAM, one write and one registered read port. Width is DATA_SIZE_ARB*PE_NUMBER, depth 2*BEATS, address is {bank, beat}.
- Packing register, counters, flags and FSM live in `bitreverse_feeder`.

## Test plan
- **Single frame:** stream words 0..511 with `in_last` on word 511.
  - First beat appears 2 edges after the last handshake.
  - 16 beats follow with `br_cycle` 0..15 and `br_first` only on beat 0.
  - Beat b lane k equals 32*b+k; `frame_err=0`.
- **Back-to-back:** three frames at 1 word/cycle.
  - `in_ready` stays 1 throughout.
  - Frame boundaries show zero-gap drains where applicable, with `br_cycle` wrapping 15→0.
- **Backpressure:** stall the drain by filling both banks via a test-only hold (force FSM IDLE).
  - `in_ready=0` after word 1023.
  - Release → word 1024 is accepted in the cycle after bank 0 frees.
- **Framing error:** `in_last` on word 100 → `frame_err` rises the next cycle and stays set. The frame still closes at word 511.
- **Reset mid-frame:** reset after 300 words.
  - All outputs return to reset values the next cycle.
  - A fresh 512-word frame drains with correct lane data.
- **Random valid:** `in_valid` at 30% duty → output beats match a reference model bit-exactly. `br_valid` is contiguous per frame.
